lfsr_seq: RTL

LFSR_SEQ -- requirements
Module: lfsr_seq

---
 rtl/lfsr_seq.sv | 70 +++++++
 1 files changed

// File: rtl/lfsr_seq.sv
// lfsr_seq: Fibonacci LFSR with step counter, period-return pulse and lock-up detect.
// Define LFSR_SEQ_STUCK_RECOVER_EN to reload SEED when stepping from the all-zero state.
module lfsr_seq #(
    parameter int               WIDTH = 5,
    parameter logic [WIDTH-1:0] TAPS  = 5'b10010,
    parameter logic [WIDTH-1:0] SEED  = '1,
    parameter int               CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             set,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             en,
    output logic             out,
    output logic [WIDTH-1:0] state,
    output logic [CNT_W-1:0] cnt,
    output logic             period,
    output logic             stuck
);
    logic [WIDTH-1:0] state_q, state_d, seed_q, seed_d, step;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             period_q, period_d;
    always_comb begin
        step     = {state_q[WIDTH-2:0], ^(state_q & TAPS)};
        state_d  = state_q;
        seed_d   = seed_q;
        cnt_d    = cnt_q;
        period_d = 1'b0;
        if (set) begin
            state_d = SEED;
            seed_d  = SEED;
            cnt_d   = '0;
        end else if (load) begin
            state_d = load_data;
            seed_d  = load_data;
            cnt_d   = '0;
        end else if (en) begin
`ifdef LFSR_SEQ_STUCK_RECOVER_EN
            if (state_q == '0) begin
                state_d = SEED;
                cnt_d   = '0;
            end else
`endif
            begin
                state_d  = step;
                period_d = (step == seed_q);
                cnt_d    = period_d ? '0 : cnt_q + CNT_W'(1);
            end
        end
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= SEED;
            seed_q   <= SEED;
            cnt_q    <= '0;
            period_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            seed_q   <= seed_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
        end
    end
    assign state  = state_q;
    assign out    = state_q[WIDTH-1];
    assign cnt    = cnt_q;
    assign period = period_q;
    assign stuck  = (state_q == '0);
endmodule
